uart_tx_frame_gen: RTL and testbench
====================================

// Module: uart_tx_frame_gen
// PURPOSE
//  UART transmit path: accepts a parallel byte from the SoC register/FIFO side and
//  shifts it out as one asynchronous serial frame: start, DATA_WIDTH data bits
//  LSB-first, optional parity, one stop bit. Counterpart of the UART RX path and
//  must produce frames that the RX path decodes bit-exactly. CLK is the TX bit
//  clock (one serial bit per CLK period), supplied by the SoC clock divider.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame (>=5)
// PORTS
//  CLK         in   1           TX bit clock
//  RST         in   1           asynchronous, active-low reset
//  P_DATA      in   DATA_WIDTH  parallel payload; sampled only at acceptance
//  Data_Valid  in   1           payload request; accepted only when Busy==0
//  PAR_EN      in   1           1 = insert parity bit; sampled at acceptance
//  PAR_TYP     in   1           0 = even, 1 = odd; sampled at acceptance
//  TX_OUT      out  1           serial line, idle high; registered
//  Busy        out  1           frame in progress; registered
// BEHAVIOUR
//  - Reset: TX_OUT=1, Busy=0, FSM=IDLE, shift reg/bit counter/latched cfg cleared.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//  - IDLE: TX_OUT=1, Busy=0. On edge with Data_Valid=1: latch P_DATA, PAR_EN, PAR_TYP,
//    compute parity from latched data; go START. TX_OUT=0, Busy=1 from that same edge.
//  - START (1 cycle) -> DATA. DATA: DATA_WIDTH cycles, bit i on cycle i, LSB first;
//    bit counter 0..DATA_WIDTH-1, counter width $clog2(DATA_WIDTH).
//  - After last data bit: PARITY if latched PAR_EN=1, else STOP.
//  - PARITY (1 cycle): even -> XOR of data bits; odd -> inverted XOR.
//  - STOP (1 cycle): TX_OUT=1, Busy=1; then IDLE (Busy=0, TX_OUT=1 at next edge).
//  - Frame length = 2 + DATA_WIDTH + PAR_EN cycles; Busy high exactly that long.
//  - Data_Valid while Busy=1 (incl. STOP cycle) is ignored, no queuing; inputs
//    P_DATA/PAR_EN/PAR_TYP may change freely mid-frame with no effect.
//  - Back-to-back: Data_Valid held high -> new frame accepted on first IDLE edge;
//    minimum line-idle gap between frames = 1 cycle (stop + 1 idle).
//  - Reset mid-frame: immediate abort, TX_OUT=1, Busy=0; frame discarded, no resume.
//  - No glitches on TX_OUT: driven only from a flop.
// STRUCTURE
//  - Shared package uart_pkg: FSM state encoding, PAR_EVEN=0 / PAR_ODD=1 constants,
//    START_BIT=0 / STOP_BIT=1 constants (shared with the RX path).
//  - One sub-module: uart_tx_parity_calc (DATA_WIDTH data + type -> parity bit,
//    combinational). FSM, shift register, counter and output mux stay in top.
// TESTING
//  - 0xA5, PAR_EN=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,1 then 1; Busy high 10 cycles.
//  - 0xA5, PAR_EN=1 even -> parity 0, frame 11 cycles; odd -> parity 1.
//  - 0x01, PAR_EN=1, even -> parity 1; 0x00 odd -> parity 1; 0xFF even -> parity 0.
//  - Data_Valid pulses with 0xFF at cycles 3 and STOP of a 0x3C frame -> ignored;
//    0x3C frame bit-exact, no second frame.
//  - Data_Valid held high, P_DATA 0x55 then 0xAA -> two frames, 1 idle-high cycle gap.
//  - RST low at DATA bit 4 -> TX_OUT=1, Busy=0 same cycle; after release idle until
//    next Data_Valid; RX-path loopback decodes all frames above without error.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM encoding plus line-level constants used by TX and RX.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: even parity is the XOR of the data, odd is its inverse.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Odd parity flips the reduction so the total count of ones becomes odd.
  always_comb begin
    par_bit = (^data) ^ (par_typ == PAR_ODD);
  end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop
// bit. One serial bit per CLK period; TX_OUT and Busy come straight from flops.
module uart_tx_frame_gen
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

  uart_tx_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_calc;

  // Parity is taken from the payload on the acceptance edge, i.e. the same value that is latched.
  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_calc)
  );

  // Next-state logic; tx_d/busy_d hold the line value for the state being entered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    unique case (state_q)
      StIdle: begin
        tx_d   = STOP_BIT;
        busy_d = 1'b0;
        if (Data_Valid) begin
          state_d   = StStart;
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = par_calc;
          cnt_d     = '0;
          tx_d      = START_BIT;
          busy_d    = 1'b1;
        end
      end
      StStart: begin
        state_d = StData;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
      end
      StData: begin
        if (cnt_q == LastIdx) begin
          if (par_en_q) begin
            state_d = StParity;
            tx_d    = par_bit_q;
          end else begin
            state_d = StStop;
            tx_d    = STOP_BIT;
          end
        end else begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      StParity: begin
        state_d = StStop;
        tx_d    = STOP_BIT;
      end
      StStop: begin
        // Data_Valid is deliberately ignored here; a new frame starts no earlier than IDLE.
        state_d = StIdle;
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and returns the line to idle-high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Self-checking bench: expected frames are queued at stimulus time and a loopback receiver
// on the serial line pops and compares them bit by bit, together with Busy.
module tb_uart_tx_frame_gen;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_bit;
  } frame_t;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int frames_started = 0;
  int frames_done    = 0;
  frame_t exp_q[$];
  int     starts[$];

  uart_tx_frame_gen #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Loopback receiver: decodes each frame on the line against the next expected frame.
  logic [15:0] mon_bits;
  int          mon_len;
  int          mon_idx;
  bit          mon_active = 0;
  bit          post_stop  = 0;

  initial begin
    frame_t f;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (mon_active) begin
          check_eq("abort_tx", TX_OUT, 1);
          check_eq("abort_busy", Busy, 0);
          mon_active = 0;
        end
        post_stop = 0;
      end else if (mon_active) begin
        check_eq("frame_bit", TX_OUT, mon_bits[mon_idx]);
        check_eq("frame_busy", Busy, 1);
        if (mon_idx == mon_len - 1) begin
          mon_active = 0;
          post_stop  = 1;
          frames_done++;
        end else begin
          mon_idx++;
        end
      end else if (post_stop) begin
        check_eq("gap_tx", TX_OUT, 1);
        check_eq("gap_busy", Busy, 0);
        post_stop = 0;
      end else if (TX_OUT == 1'b0) begin
        frames_started++;
        starts.push_back(cyc);
        check_eq("start_busy", Busy, 1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_frame", exp_q.size(), 1);
        end else begin
          f = exp_q.pop_front();
          mon_bits = '0;
          for (int i = 0; i < 8; i++) mon_bits[1+i] = f.data[i];
          mon_len = 10;
          if (f.par_en) begin
            mon_bits[9] = f.par_bit;
            mon_len     = 11;
          end
          mon_bits[mon_len-1] = 1'b1;
          mon_idx    = 1;
          mon_active = 1;
        end
      end else begin
        check_eq("idle_busy", Busy, 0);
      end
    end
  end

  // Drive one single-cycle request; returns just after the acceptance edge.
  task automatic send(input logic [7:0] d, input logic en, input logic typ);
    @(posedge CLK);
    #1;
    P_DATA     = d;
    PAR_EN     = en;
    PAR_TYP    = typ;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic en, input logic pbit);
    frame_t f;
    f.data    = d;
    f.par_en  = en;
    f.par_bit = pbit;
    exp_q.push_back(f);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (frames_done < target && t < 100) begin
      @(posedge CLK);
      t++;
    end
    check_eq("wait_done", frames_done, target);
    repeat (3) @(posedge CLK);
  endtask

  // Parity cases: data, PAR_TYP, expected parity bit.
  logic [7:0] par_data[5] = '{8'hA5, 8'hA5, 8'h01, 8'h00, 8'hFF};
  logic       par_typ[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       par_exp[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int done_tgt;
    int st0;
    RST        = 1'b0;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    #12;
    check_eq("reset_tx", TX_OUT, 1);
    check_eq("reset_busy", Busy, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (3) @(posedge CLK);

    // 0xA5 without parity: 10-cycle frame.
    done_tgt = 0;
    push_exp(8'hA5, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b0);
    done_tgt++;
    wait_done(done_tgt);

    // Parity table.
    for (int i = 0; i < 5; i++) begin
      push_exp(par_data[i], 1'b1, par_exp[i]);
      send(par_data[i], 1'b1, par_typ[i]);
      done_tgt++;
      wait_done(done_tgt);
    end

    // 0x3C frame with stray requests at DATA time and at STOP; inputs churn mid-frame.
    st0 = frames_started;
    push_exp(8'h3C, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    P_DATA  = 8'hFF;
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK);
      #1;
      Data_Valid = (k == 2 || k == 9);
    end
    Data_Valid = 1'b0;
    done_tgt++;
    wait_done(done_tgt);
    repeat (10) @(posedge CLK);
    check_eq("ignored_no_frame", frames_started - st0, 1);

    // Back-to-back with Data_Valid held: 0x55 then 0xAA, one idle cycle between.
    st0 = starts.size();
    push_exp(8'h55, 1'b0, 1'b0);
    push_exp(8'hAA, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    P_DATA     = 8'h55;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1 P_DATA = 8'hAA;
    repeat (11) @(posedge CLK);
    #1 Data_Valid = 1'b0;
    done_tgt += 2;
    wait_done(done_tgt);
    if (starts.size() >= st0 + 2) begin
      check_eq("b2b_spacing", starts[st0+1] - starts[st0], 11);
    end else begin
      check_eq("b2b_frames", starts.size() - st0, 2);
    end

    // Reset asserted during DATA bit 4 aborts the frame immediately.
    st0 = frames_started;
    push_exp(8'hC3, 1'b1, 1'b0);
    send(8'hC3, 1'b1, 1'b0);
    repeat (5) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check_eq("rst_mid_tx", TX_OUT, 1);
    check_eq("rst_mid_busy", Busy, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (8) @(posedge CLK);
    check_eq("rst_no_resume", frames_started - st0, 1);
    check_eq("rst_done_count", frames_done, done_tgt);

    // Recovery frame after the abort.
    push_exp(8'h96, 1'b1, 1'b1);
    send(8'h96, 1'b1, 1'b1);
    done_tgt++;
    wait_done(done_tgt);

    check_eq("exp_queue_empty", exp_q.size(), 0);
    check_eq("frames_started", frames_started, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
